mem_arbiter: RTL and testbench

// Shares the single-port 256x16 program/data RAM between two requesters: the CPU memory port
// (port 0) and a debug/loader port (port 1) that preloads or inspects memory while the CPU runs.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   MNONE/MREAD/MWRITE : requester command encodings (2'b11 is never granted)
//   arb_state_t        : arbiter FSM states
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  // Only MREAD and MWRITE count as a request; 2'b11 behaves like MNONE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select.
//   i_req[1:0]     : request per port (bit 0 = CPU, bit 1 = debug)
//   i_last_winner  : port granted most recently
//   o_valid        : at least one port requests
//   o_winner       : selected port id
// CPU_PRIORITY=1 resolves ties to port 0; otherwise ties go to the port that did not win last.
module rr_pick2 #(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_winner,
  output logic       o_valid,
  output logic       o_winner
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    if (i_req == 2'b11) begin
      o_winner = CPU_PRIORITY ? 1'b0 : ~i_last_winner;
    end else begin
      o_winner = i_req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 256xDATA_W RAM between the CPU port (0) and a debug/loader port (1).
// One transaction in flight; the winner's cmd/addr/wdata are latched at grant so the losing
// port never reaches the RAM.
//   clk, reset (async, active low)
//   cpu_*/dbg_* : request cmd, address, write data in; read data and done pulse out
//   ram_*       : RAM address, write data, write enable out; registered read data in
// Addresses with the top bit set are I/O space: normal timing, no RAM write, rdata = 0.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 16,
  parameter bit          CPU_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic [1:0]        dbg_mem_cmd,
  input  logic [ADDR_W-1:0] dbg_mem_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [7:0]        ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_t        r_state, w_state_d;
  logic              r_last_winner;
  logic              r_winner;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_grant_valid;
  logic              w_winner;
  logic [1:0]        w_req;
  logic              w_io;
  logic              w_wr_done;
  logic              w_rd_done;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_req = {is_req(dbg_mem_cmd), is_req(cpu_mem_cmd)};

  rr_pick2 #(
    .CPU_PRIORITY(CPU_PRIORITY)
  ) u_pick (
    .i_req        (w_req),
    .i_last_winner(r_last_winner),
    .o_valid      (w_grant_valid),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_valid) w_state_d = ACCESS;
      ACCESS:  w_state_d = (r_cmd == MREAD) ? RESP : IDLE;
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_winner <= 1'b1;
      r_winner      <= 1'b0;
      r_cmd         <= MNONE;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && w_grant_valid) begin
        r_winner      <= w_winner;
        r_last_winner <= w_winner;
        r_cmd         <= w_winner ? dbg_mem_cmd  : cpu_mem_cmd;
        r_addr        <= w_winner ? dbg_mem_addr : cpu_mem_addr;
        r_wdata       <= w_winner ? dbg_wdata    : cpu_wdata;
      end
    end
  end

  // Outputs decode straight from state so reset clears them in the same time step.
  always_comb begin
    w_io      = r_addr[ADDR_W-1];
    w_wr_done = (r_state == ACCESS) && (r_cmd == MWRITE);
    w_rd_done = (r_state == RESP);
    w_done    = w_wr_done || w_rd_done;
    w_rdata   = (w_rd_done && !w_io) ? ram_dout : '0;
  end

  assign ram_addr  = r_addr[7:0];
  assign ram_din   = r_wdata;
  assign ram_write = w_wr_done && !w_io;
  assign cpu_done  = w_done && !r_winner;
  assign dbg_done  = w_done && r_winner;
  assign cpu_rdata = r_winner ? '0 : w_rdata;
  assign dbg_rdata = r_winner ? w_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] CN = 2'b00;
  localparam logic [1:0] CR = 2'b01;
  localparam logic [1:0] CW = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_mem_cmd, dbg_mem_cmd;
  logic [8:0]  cpu_mem_addr, dbg_mem_addr;
  logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic        cpu_done, dbg_done;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        ram_write;

  // Second instance in fixed-priority mode
  logic [1:0]  p_cpu_cmd, p_dbg_cmd;
  logic [8:0]  p_cpu_addr, p_dbg_addr;
  logic [15:0] p_cpu_wdata, p_dbg_wdata, p_cpu_rdata, p_dbg_rdata;
  logic        p_cpu_done, p_dbg_done;
  logic [7:0]  p_ram_addr;
  logic [15:0] p_ram_din;
  logic [15:0] p_ram_dout = 16'h0000;
  logic        p_ram_write;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .CPU_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_mem_cmd(dbg_mem_cmd), .dbg_mem_addr(dbg_mem_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .CPU_PRIORITY(1'b1)) dut_pri (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(p_cpu_cmd), .cpu_mem_addr(p_cpu_addr), .cpu_wdata(p_cpu_wdata),
    .cpu_rdata(p_cpu_rdata), .cpu_done(p_cpu_done),
    .dbg_mem_cmd(p_dbg_cmd), .dbg_mem_addr(p_dbg_addr), .dbg_wdata(p_dbg_wdata),
    .dbg_rdata(p_dbg_rdata), .dbg_done(p_dbg_done),
    .ram_addr(p_ram_addr), .ram_din(p_ram_din), .ram_write(p_ram_write),
    .ram_dout(p_ram_dout)
  );

  // RAM model: registered read, preloaded with {a,a}^5A5A on the first edge.
  logic [15:0] mem0 [256];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= {i[7:0], i[7:0]} ^ 16'h5A5A;
      mem_init <= 1'b1;
    end else if (ram_write) begin
      mem0[ram_addr] <= ram_din;
    end
    ram_dout <= mem0[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard: every done pulse of the RR instance must match the oldest expectation.
  always @(negedge clk) begin
    if (cpu_done || dbg_done) begin
      exp_t e;
      n_done++;
      chk("done_exclusive", {31'd0, cpu_done & dbg_done}, 32'd0);
      chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_port", {31'd0, dbg_done}, {31'd0, e.port});
        chk("sb_rdata", {16'd0, dbg_done ? dbg_rdata : cpu_rdata}, {16'd0, e.rdata});
      end
    end
  end

  typedef struct {
    logic        port;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    logic        exp_wr;
  } vec_t;

  task automatic idle_ports();
    cpu_mem_cmd = CN; cpu_mem_addr = '0; cpu_wdata = '0;
    dbg_mem_cmd = CN; dbg_mem_addr = '0; dbg_wdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0;
    bit seen = 1'b0;
    bit wr_seen = 1'b0;
    if (v.port) begin
      dbg_mem_cmd = v.cmd; dbg_mem_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_mem_cmd = v.cmd; cpu_mem_addr = v.addr; cpu_wdata = v.wdata;
    end
    sb_q.push_back('{port: v.port, rdata: v.exp_rdata});
    while (!seen && lat < 8) begin
      step();
      lat++;
      if (ram_write) begin
        wr_seen = 1'b1;
        chk("wr_addr", {24'd0, ram_addr}, {24'd0, v.addr[7:0]});
        chk("wr_data", {16'd0, ram_din}, {16'd0, v.wdata});
      end
      seen = v.port ? dbg_done : cpu_done;
    end
    chk("latency", lat, v.exp_lat);
    chk("ram_write_seen", {31'd0, wr_seen}, {31'd0, v.exp_wr});
    idle_ports();
    step();
  endtask

  vec_t vecs[10];
  int   base;
  int   pc, pd;

  initial begin
    vecs[0] = '{1'b1, CW, 9'h003, 16'hD40F, 16'h0000, 1, 1'b1};
    vecs[1] = '{1'b0, CR, 9'h003, 16'h0000, 16'hD40F, 2, 1'b0};
    vecs[2] = '{1'b0, CW, 9'h100, 16'h00FF, 16'h0000, 1, 1'b0};
    vecs[3] = '{1'b0, CR, 9'h140, 16'h0000, 16'h0000, 2, 1'b0};
    vecs[4] = '{1'b1, CR, 9'h003, 16'h0000, 16'hD40F, 2, 1'b0};
    vecs[5] = '{1'b0, CW, 9'h0FF, 16'h1234, 16'h0000, 1, 1'b1};
    vecs[6] = '{1'b1, CR, 9'h0FF, 16'h0000, 16'h1234, 2, 1'b0};
    vecs[7] = '{1'b1, CW, 9'h1FF, 16'hABCD, 16'h0000, 1, 1'b0};
    vecs[8] = '{1'b0, CR, 9'h0FF, 16'h0000, 16'h1234, 2, 1'b0};
    vecs[9] = '{1'b1, CR, 9'h010, 16'h0000, 16'h4A4A, 2, 1'b0};

    idle_ports();
    p_cpu_cmd = CN; p_cpu_addr = '0; p_cpu_wdata = '0;
    p_dbg_cmd = CN; p_dbg_addr = '0; p_dbg_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_done", {30'd0, cpu_done, dbg_done}, 32'd0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    reset = 1'b1;
    step();

    // cmd 2'b11 on both ports is never granted
    cpu_mem_cmd = 2'b11; dbg_mem_cmd = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("c11_ram_write", {31'd0, ram_write}, 32'd0);
      chk("c11_done", {30'd0, cpu_done, dbg_done}, 32'd0);
      chk("c11_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    end
    idle_ports();
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    chk("io_write_ram_unchanged", {16'd0, mem0[8'h00]}, 32'h5A5A);

    // Reset in the middle of a write access aborts it
    dbg_mem_cmd = CW; dbg_mem_addr = 9'h005; dbg_wdata = 16'hBEEF;
    step();
    chk("abort_pre_write", {31'd0, ram_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ram_write", {31'd0, ram_write}, 32'd0);
    chk("abort_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("abort_ram_din", {16'd0, ram_din}, 32'd0);
    chk("abort_done", {30'd0, cpu_done, dbg_done}, 32'd0);
    chk("abort_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    idle_ports();
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_ram_unchanged", {16'd0, mem0[8'h05]}, 32'h5F5F);

    // Round-robin with both ports reading persistently after reset
    cpu_mem_cmd = CR; cpu_mem_addr = 9'h003;
    dbg_mem_cmd = CR; dbg_mem_addr = 9'h0FF;
    sb_q.push_back('{port: 1'b0, rdata: 16'hD40F});
    sb_q.push_back('{port: 1'b1, rdata: 16'h1234});
    sb_q.push_back('{port: 1'b0, rdata: 16'hD40F});
    sb_q.push_back('{port: 1'b1, rdata: 16'h1234});
    base = n_done;
    for (int i = 0; i < 20; i++) begin
      step();
      if (n_done >= base + 4) break;
    end
    idle_ports();
    step();
    step();
    chk("rr_done_count", n_done - base, 4);

    // Fixed priority: CPU wins every tie, debug starves
    p_cpu_cmd = CR; p_cpu_addr = 9'h003;
    p_dbg_cmd = CR; p_dbg_addr = 9'h0FF;
    pc = 0; pd = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (p_cpu_done) pc++;
      if (p_dbg_done) pd++;
    end
    p_cpu_cmd = CN; p_dbg_cmd = CN;
    step();
    chk("pri_cpu_dones", pc, 10);
    chk("pri_dbg_dones", pd, 0);

    step();
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
